matrix_loader: RTL and testbench

// - Upstream feeder for the matrix transpose stage. Accepts dimensions m x n (1..5) and then m*n
//   8-bit elements, one per valid/ready handshake, in row-major order.
// - Packs the elements into a 5x5 row-major 200-bit bus: element (i,j) goes to bits [(i*5+j)*8 +: 8].
// - Unused slots are zero. Presents m, n and the matrix with a held valid flag until the consumer acks.

---
 rtl/matrix_loader_if.sv | 34 +++
 rtl/matrix_loader.sv | 127 ++++++++++++
 tb/tb_matrix_loader.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_loader_if.sv
// Handshake and result bus between the matrix loader and its neighbours.
// master: the element source / matrix consumer side; slave: the loader.
interface matrix_loader_if #(
    parameter int DIM_MAX = 5,
    parameter int ELEM_W  = 8
);
    localparam int MAT_W = DIM_MAX * DIM_MAX * ELEM_W;

    logic              start;
    logic [2:0]        m_in;
    logic [2:0]        n_in;
    logic              elem_valid;
    logic [ELEM_W-1:0] elem_data;
    logic              elem_ready;
    logic              abort;
    logic              taken;
    logic [2:0]        m_out;
    logic [2:0]        n_out;
    logic [MAT_W-1:0]  matrixA;
    logic              valid;
    logic              busy;
    logic              err_dim;
    logic              err_elem;

    modport master (
        output start, m_in, n_in, elem_valid, elem_data, abort, taken,
        input  elem_ready, m_out, n_out, matrixA, valid, busy, err_dim, err_elem
    );

    modport slave (
        input  start, m_in, n_in, elem_valid, elem_data, abort, taken,
        output elem_ready, m_out, n_out, matrixA, valid, busy, err_dim, err_elem
    );
endinterface

// File: rtl/matrix_loader.sv
// matrix_loader: collects an m x n matrix (1..DIM_MAX each) element by element
// in row-major order and presents it as a zero-padded DIM_MAX x DIM_MAX bus,
// holding valid until the consumer acks with taken.
// Optional feature macro: MATRIX_LOADER_RANGE_CHECK_EN -- elements above
// ELEM_MAX are consumed but dropped, with a one-cycle err_elem pulse.
module matrix_loader #(
    parameter int DIM_MAX  = 5,
    parameter int ELEM_W   = 8,
    parameter int ELEM_MAX = 9
) (
    input logic             clk,
    input logic             reset,
    matrix_loader_if.slave  bus
);
    localparam int SLOTS  = DIM_MAX * DIM_MAX;
    localparam int MAT_W  = SLOTS * ELEM_W;
    localparam int SLOT_W = $clog2(SLOTS);

`ifdef MATRIX_LOADER_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        m_q, n_q, row_q, col_q;
    logic [MAT_W-1:0]  mat_q;
    logic              valid_q, busy_q, err_dim_q, err_elem_q;

    logic              dims_ok, hs, elem_bad, wr_en;
    logic              last_col, last_elem, load_start, load_abort;
    logic [SLOT_W-1:0] slot;

    // Next state plus the per-cycle decode that the datapath acts on.
    always_comb begin
        state_d    = state_q;
        load_start = 1'b0;
        load_abort = 1'b0;
        wr_en      = 1'b0;
        dims_ok    = (bus.m_in != 3'd0) && (bus.m_in <= 3'(DIM_MAX)) &&
                     (bus.n_in != 3'd0) && (bus.n_in <= 3'(DIM_MAX));
        hs         = bus.elem_valid && (state_q == LOAD);
        elem_bad   = RANGE_EN && (bus.elem_data > ELEM_W'(ELEM_MAX));
        last_col   = (col_q == n_q - 3'd1);
        last_elem  = last_col && (row_q == m_q - 3'd1);
        slot       = SLOT_W'(int'(row_q) * DIM_MAX + int'(col_q));
        case (state_q)
            IDLE: begin
                if (bus.start && dims_ok) begin
                    load_start = 1'b1;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                // abort wins over a same-cycle element, which is dropped
                if (bus.abort) begin
                    load_abort = 1'b1;
                    state_d    = IDLE;
                end else if (hs && !elem_bad) begin
                    wr_en = 1'b1;
                    if (last_elem) state_d = DONE;
                end
            end
            DONE: begin
                if (bus.taken) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Registered outputs, dimension latches, position counters and buffer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            err_dim_q  <= 1'b0;
            err_elem_q <= 1'b0;
            m_q        <= '0;
            n_q        <= '0;
            row_q      <= '0;
            col_q      <= '0;
            mat_q      <= '0;
        end else begin
            valid_q    <= (state_d == DONE);
            busy_q     <= (state_d != IDLE);
            err_dim_q  <= (state_q == IDLE) && bus.start && !dims_ok;
            err_elem_q <= hs && !bus.abort && elem_bad;
            if (load_start || load_abort) begin
                mat_q <= '0;
                row_q <= '0;
                col_q <= '0;
                m_q   <= load_start ? bus.m_in : 3'd0;
                n_q   <= load_start ? bus.n_in : 3'd0;
            end else if (wr_en) begin
                for (int k = 0; k < SLOTS; k++)
                    if (slot == SLOT_W'(k)) mat_q[k*ELEM_W +: ELEM_W] <= bus.elem_data;
                // counters park at 0 after the last element so they stay in range
                if (last_elem) begin
                    row_q <= '0;
                    col_q <= '0;
                end else if (last_col) begin
                    col_q <= '0;
                    row_q <= row_q + 3'd1;
                end else begin
                    col_q <= col_q + 3'd1;
                end
            end
        end
    end

    assign bus.elem_ready = (state_q == LOAD);
    assign bus.m_out      = m_q;
    assign bus.n_out      = n_q;
    assign bus.matrixA    = mat_q;
    assign bus.valid      = valid_q;
    assign bus.busy       = busy_q;
    assign bus.err_dim    = err_dim_q;
    assign bus.err_elem   = err_elem_q;
endmodule

// File: tb/tb_matrix_loader.sv
// Bench for matrix_loader: directed loads checked every cycle against a
// queue-based model of the accepted elements, plus hand-computed literals.
module tb_matrix_loader;
    logic clk = 1'b0;
    logic rst_n;

    matrix_loader_if #(.DIM_MAX(5), .ELEM_W(8)) bus();

    matrix_loader #(.DIM_MAX(5), .ELEM_W(8), .ELEM_MAX(9)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

`ifdef MATRIX_LOADER_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    int unsigned total = 0;
    int unsigned bad   = 0;
    bit          cmp_en = 1'b0;

    // model: a load is "active" from an accepted start until taken/abort;
    // it is presenting once m*n elements have been accepted
    bit          m_act  = 1'b0;
    int          m_m    = 0;
    int          m_n    = 0;
    byte unsigned m_q[$];
    bit          m_errd = 1'b0;
    bit          m_erre = 1'b0;

    task automatic chk(input string nm, input logic [199:0] act, input logic [199:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [199:0] exp_mat();
        logic [199:0] r;
        r = '0;
        for (int k = 0; k < m_q.size(); k++)
            r[((k / m_n) * 5 + (k % m_n)) * 8 +: 8] = m_q[k];
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act = 1'b0; m_m = 0; m_n = 0; m_q.delete(); m_errd = 1'b0; m_erre = 1'b0;
        end else begin
            m_errd = 1'b0;
            m_erre = 1'b0;
            if (!m_act) begin
                if (bus.start) begin
                    if (bus.m_in >= 1 && bus.m_in <= 5 && bus.n_in >= 1 && bus.n_in <= 5) begin
                        m_act = 1'b1; m_m = int'(bus.m_in); m_n = int'(bus.n_in); m_q.delete();
                    end else m_errd = 1'b1;
                end
            end else if (m_q.size() < m_m * m_n) begin
                if (bus.abort) begin
                    m_act = 1'b0; m_m = 0; m_n = 0; m_q.delete();
                end else if (bus.elem_valid) begin
                    if (RANGE_EN && bus.elem_data > 8'd9) m_erre = 1'b1;
                    else m_q.push_back(bus.elem_data);
                end
            end else if (bus.taken) m_act = 1'b0;
        end
    end

    // every-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("elem_ready", bus.elem_ready, m_act && (m_q.size() < m_m * m_n));
            chk("busy",       bus.busy,       m_act);
            chk("valid",      bus.valid,      m_act && (m_q.size() == m_m * m_n));
            chk("m_out",      bus.m_out,      m_m);
            chk("n_out",      bus.n_out,      m_n);
            chk("matrixA",    bus.matrixA,    exp_mat());
            chk("err_dim",    bus.err_dim,    m_errd);
            chk("err_elem",   bus.err_elem,   m_erre);
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_start(input int mm, input int nn);
        bus.start = 1'b1; bus.m_in = 3'(mm); bus.n_in = 3'(nn);
        cycles(1);
        bus.start = 1'b0;
    endtask

    // present one element and wait for its handshake; valid stays high
    task automatic push(input int d);
        bit hs;
        int cnt;
        cnt = 0;
        bus.elem_valid = 1'b1;
        bus.elem_data  = 8'(d);
        do begin
            hs = bus.elem_ready;
            cycles(1);
            cnt++;
        end while (!hs && cnt < 50);
        if (!hs) begin
            total++; bad++;
            $display("FAIL push_timeout: got no handshake want handshake for elem %0d", d);
        end
    endtask

    logic [199:0] snap;

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0; bus.m_in = '0; bus.n_in = '0;
        bus.elem_valid = 1'b0; bus.elem_data = '0;
        bus.abort = 1'b0; bus.taken = 1'b0;
        cycles(2);
        chk("reset_valid", bus.valid, 0);
        chk("reset_busy",  bus.busy, 0);
        chk("reset_mat",   bus.matrixA, 0);
        chk("reset_ready", bus.elem_ready, 0);
        rst_n = 1'b1;
        cmp_en = 1'b1;
        cycles(1);

        // illegal dimensions
        do_start(0, 3);
        chk("errdim_a", bus.err_dim, 1);
        chk("errdim_a_busy", bus.busy, 0);
        cycles(1);
        chk("errdim_a_clr", bus.err_dim, 0);
        do_start(6, 2);
        chk("errdim_b", bus.err_dim, 1);
        chk("errdim_b_ready", bus.elem_ready, 0);
        cycles(1);

        // 2x3 back to back
        do_start(2, 3);
        for (int k = 1; k <= 6; k++) push(k);
        bus.elem_valid = 1'b0;
        chk("l23_valid", bus.valid, 1);
        chk("l23_m", bus.m_out, 2);
        chk("l23_n", bus.n_out, 3);
        chk("l23_mat", bus.matrixA, 200'h0605040000030201);
        // abort together with taken: taken wins
        bus.taken = 1'b1; bus.abort = 1'b1;
        cycles(1);
        bus.taken = 1'b0; bus.abort = 1'b0;
        chk("l23_taken_valid", bus.valid, 0);
        chk("l23_kept_mat", bus.matrixA, 200'h0605040000030201);
        cycles(1);

        // 3x3 with abort on a 5th element
        do_start(3, 3);
        for (int k = 1; k <= 4; k++) push(k);
        bus.elem_data = 8'd5; bus.abort = 1'b1;
        cycles(1);
        bus.abort = 1'b0; bus.elem_valid = 1'b0;
        chk("abort_busy", bus.busy, 0);
        chk("abort_mat", bus.matrixA, 0);
        chk("abort_m", bus.m_out, 0);
        do_start(1, 1);
        push(7);
        bus.elem_valid = 1'b0;
        chk("l11_mat", bus.matrixA, 200'h07);
        chk("l11_valid", bus.valid, 1);
        bus.taken = 1'b1; cycles(1); bus.taken = 1'b0;
        cycles(1);

        // 5x5 with gaps, then a 10-cycle hold
        do_start(5, 5);
        for (int k = 0; k < 25; k++) begin
            bus.elem_valid = 1'b0;
            cycles($urandom_range(0, 2));
            push(k + 1);
        end
        bus.elem_valid = 1'b0;
        snap = bus.matrixA;
        chk("l55_byte0", snap[7:0], 8'd1);
        chk("l55_byte24", snap[199:192], 8'd25);
        for (int c = 0; c < 10; c++) begin
            bus.abort = (c == 3);
            bus.start = (c == 6); bus.m_in = 3'd1; bus.n_in = 3'd1;
            cycles(1);
            chk("hold_valid", bus.valid, 1);
            chk("hold_mat", bus.matrixA, snap);
        end
        bus.abort = 1'b0; bus.start = 1'b0;
        bus.taken = 1'b1; cycles(1); bus.taken = 1'b0;
        chk("l55_release", bus.valid, 0);
        cycles(1);

        // range check: 1x2 with 3, 12, 4
        do_start(1, 2);
        push(3);
        push(12);
`ifdef MATRIX_LOADER_RANGE_CHECK_EN
        chk("range_err", bus.err_elem, 1);
        push(4);
        bus.elem_valid = 1'b0;
        chk("range_mat", bus.matrixA, 200'h0403);
`else
        bus.elem_valid = 1'b0;
        chk("norange_err", bus.err_elem, 0);
        chk("norange_mat", bus.matrixA, 200'h0c03);
`endif
        chk("range_valid", bus.valid, 1);
        bus.taken = 1'b1; cycles(1); bus.taken = 1'b0;
        cycles(1);

        // reset in the middle of a 2x2 load
        do_start(2, 2);
        push(1);
        push(2);
        bus.elem_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_ready", bus.elem_ready, 0);
        chk("midrst_m", bus.m_out, 0);
        chk("midrst_mat", bus.matrixA, 0);
        cycles(2);
        rst_n = 1'b1;
        cycles(1);
        do_start(2, 2);
        for (int k = 1; k <= 4; k++) push(k);
        bus.elem_valid = 1'b0;
        chk("l22_mat", bus.matrixA, 200'h04030000000201);
        chk("l22_valid", bus.valid, 1);
        bus.taken = 1'b1; cycles(1); bus.taken = 1'b0;
        cycles(2);

        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
